// File: rtl/avaliador_ativos.sv
// Active-node evaluator: applies one serialized neighbour-update command to the
// node-state memory and pushes every improved node into the active set.
module avaliador_ativos #(
  parameter int ADDR_WIDTH      = 10,
  parameter int DISTANCIA_WIDTH = 6,
  parameter int CUSTO_WIDTH     = 4,
  parameter int NUM_READ_PORTS  = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  limpar_in,
  input  logic                                  oe_atualizar_in,
  input  logic [NUM_READ_PORTS-1:0]             oe_vizinho_valido_in,
  input  logic [ADDR_WIDTH*NUM_READ_PORTS-1:0]  oe_endereco_in,
  input  logic [CUSTO_WIDTH*NUM_READ_PORTS-1:0] oe_menor_vizinho_in,
  input  logic [DISTANCIA_WIDTH*NUM_READ_PORTS-1:0] oe_distancia_in,
  input  logic [ADDR_WIDTH-1:0]                 oe_anterior_in,
  output logic                                  aa_atualizar_ready_out,
  output logic                                  aa_ocupado_out,
  output logic                                  aa_ativo_valid_out,
  input  logic                                  aa_ativo_ready_in,
  output logic [ADDR_WIDTH-1:0]                 aa_ativo_endereco_out,
  output logic [DISTANCIA_WIDTH:0]              aa_ativo_custo_out
);

  localparam int DEPTH   = 2**ADDR_WIDTH;
  localparam int ENTRY_W = 1 + DISTANCIA_WIDTH + ADDR_WIDTH;
  localparam int IDX_W   = (NUM_READ_PORTS > 1) ? $clog2(NUM_READ_PORTS) : 1;
  localparam int F_W     = DISTANCIA_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE, SCAN, LER, COMPARA, EMPURRA, FIM, LIMPAR
  } state_t;

  function automatic logic [F_W-1:0] calc_custo(input logic [DISTANCIA_WIDTH-1:0] g,
                                                input logic [CUSTO_WIDTH-1:0] h);
    return F_W'(g) + F_W'(h);
  endfunction

  state_t state, state_next;

  logic [NUM_READ_PORTS-1:0]                  pendente;
  logic [ADDR_WIDTH*NUM_READ_PORTS-1:0]       endereco_r;
  logic [CUSTO_WIDTH*NUM_READ_PORTS-1:0]      menor_r;
  logic [DISTANCIA_WIDTH*NUM_READ_PORTS-1:0]  distancia_r;
  logic [ADDR_WIDTH-1:0]                      anterior_r;
  logic [IDX_W-1:0]                           sel_idx, sel_r;
  logic [ADDR_WIDTH-1:0]                      limpar_cnt;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic                       rd_en;
  logic [ADDR_WIDTH-1:0]      rd_addr;
  logic                       rd_vis;
  logic [DISTANCIA_WIDTH-1:0] rd_dist;
  logic                       mem_we;
  logic [ADDR_WIDTH-1:0]      mem_waddr;
  logic [ENTRY_W-1:0]         mem_wdata;

  logic [ADDR_WIDTH-1:0]      cur_addr;
  logic [DISTANCIA_WIDTH-1:0] cur_dist;
  logic [CUSTO_WIDTH-1:0]     cur_h;
  logic                       melhora;

  // Lowest-index pending slot wins, giving slot-order processing of duplicates
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_READ_PORTS - 1; i >= 0; i--) begin
      if (pendente[i]) sel_idx = IDX_W'(i);
    end
  end

  assign cur_addr = endereco_r[sel_r*ADDR_WIDTH +: ADDR_WIDTH];
  assign cur_dist = distancia_r[sel_r*DISTANCIA_WIDTH +: DISTANCIA_WIDTH];
  assign cur_h    = menor_r[sel_r*CUSTO_WIDTH +: CUSTO_WIDTH];
  assign rd_addr  = endereco_r[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign melhora  = !rd_vis || (cur_dist < rd_dist);

  // Node memory: not reset; reads and writes never share a cycle
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (rd_en) begin
      rd_vis  <= mem[rd_addr][ENTRY_W-1];
      rd_dist <= mem[rd_addr][ENTRY_W-2 -: DISTANCIA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next             = state;
    rd_en                  = 1'b0;
    mem_we                 = 1'b0;
    mem_waddr              = cur_addr;
    mem_wdata              = {1'b1, cur_dist, anterior_r};
    aa_atualizar_ready_out = 1'b0;
    aa_ativo_valid_out     = 1'b0;
    aa_ocupado_out         = (state != IDLE);
    case (state)
      IDLE: begin
        if (oe_atualizar_in) state_next = SCAN;
        else if (limpar_in)  state_next = LIMPAR;
      end
      SCAN: begin
        if (pendente == '0) begin
          state_next = FIM;
        end else begin
          rd_en      = 1'b1;
          state_next = LER;
        end
      end
      LER: state_next = COMPARA;
      COMPARA: begin
        if (melhora) begin
          mem_we     = 1'b1;
          state_next = EMPURRA;
        end else begin
          state_next = SCAN;
        end
      end
      EMPURRA: begin
        aa_ativo_valid_out = 1'b1;
        if (aa_ativo_ready_in) state_next = SCAN;
      end
      FIM: begin
        aa_atualizar_ready_out = 1'b1;
        state_next             = IDLE;
      end
      LIMPAR: begin
        mem_we    = 1'b1;
        mem_waddr = limpar_cnt;
        mem_wdata = '0;
        if (limpar_cnt == ADDR_WIDTH'(DEPTH - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Payload latch, pending mask, push registers and clear counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendente              <= '0;
      endereco_r            <= '0;
      menor_r               <= '0;
      distancia_r           <= '0;
      anterior_r            <= '0;
      sel_r                 <= '0;
      limpar_cnt            <= '0;
      aa_ativo_endereco_out <= '0;
      aa_ativo_custo_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          limpar_cnt <= '0;
          if (oe_atualizar_in) begin
            pendente    <= oe_vizinho_valido_in;
            endereco_r  <= oe_endereco_in;
            menor_r     <= oe_menor_vizinho_in;
            distancia_r <= oe_distancia_in;
            anterior_r  <= oe_anterior_in;
          end
        end
        SCAN: sel_r <= sel_idx;
        COMPARA: begin
          if (melhora) begin
            aa_ativo_endereco_out <= cur_addr;
            aa_ativo_custo_out    <= calc_custo(cur_dist, cur_h);
          end else begin
            pendente[sel_r] <= 1'b0;
          end
        end
        EMPURRA: if (aa_ativo_ready_in) pendente[sel_r] <= 1'b0;
        LIMPAR:  limpar_cnt <= limpar_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avaliador_ativos.sv
// Directed bench for avaliador_ativos: pushes, memory contents, latency,
// back-pressure, duplicate slots and reset during a push.
module tb_avaliador_ativos;
  localparam int AW = 10;
  localparam int DW = 6;
  localparam int HW = 4;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          limpar = 1'b0;
  logic          atualizar = 1'b0;
  logic [N-1:0]  vizinho_valido = '0;
  logic [AW*N-1:0] endereco = '0;
  logic [HW*N-1:0] menor = '0;
  logic [DW*N-1:0] distancia = '0;
  logic [AW-1:0] anterior = '0;
  logic          ready_o, ocupado, valid_o;
  logic          ativo_ready = 1'b1;
  logic [AW-1:0] end_o;
  logic [DW:0]   custo_o;

  avaliador_ativos #(.ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW), .CUSTO_WIDTH(HW),
                     .NUM_READ_PORTS(N)) dut (
    .clk(clk), .rst_n(rst_n), .limpar_in(limpar), .oe_atualizar_in(atualizar),
    .oe_vizinho_valido_in(vizinho_valido), .oe_endereco_in(endereco),
    .oe_menor_vizinho_in(menor), .oe_distancia_in(distancia),
    .oe_anterior_in(anterior), .aa_atualizar_ready_out(ready_o),
    .aa_ocupado_out(ocupado), .aa_ativo_valid_out(valid_o),
    .aa_ativo_ready_in(ativo_ready), .aa_ativo_endereco_out(end_o),
    .aa_ativo_custo_out(custo_o));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int pa_q[$];
  int pc_q[$];
  int n_pulse = 0;
  int lat;
  int pulses_before;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid_o && ativo_ready) begin
      pa_q.push_back(int'(end_o));
      pc_q.push_back(int'(custo_o));
    end
    if (ready_o) n_pulse++;
  end

  function automatic logic [31:0] word(input logic v, input logic [DW-1:0] d, input logic [AW-1:0] a);
    return 32'({v, d, a});
  endfunction

  task automatic clr_payload();
    endereco = '0; menor = '0; distancia = '0;
  endtask

  task automatic set_slot(input int k, input int a, input int d, input int h);
    endereco[k*AW +: AW]  = AW'(a);
    distancia[k*DW +: DW] = DW'(d);
    menor[k*HW +: HW]     = HW'(h);
  endtask

  task automatic strobe(input logic [N-1:0] v, input logic [AW-1:0] ant);
    @(posedge clk); #1;
    vizinho_valido = v; anterior = ant; atualizar = 1'b1;
    @(posedge clk); #1;
    atualizar = 1'b0;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cycles++;
      if (ready_o) break;
    end
    @(negedge clk);
    check("pulse_one_cycle", ready_o, 1'b0);
    check("ocupado_after", ocupado, 1'b0);
  endtask

  task automatic fire(input logic [N-1:0] v, input logic [AW-1:0] ant, output int cycles);
    strobe(v, ant);
    check("ocupado_during", ocupado, 1'b1);
    wait_ready(cycles);
  endtask

  task automatic chk_push(input string tag, input int a, input int c);
    if (pa_q.size() > 0) begin
      check({tag, "_addr"}, pa_q.pop_front(), a);
      check({tag, "_custo"}, pc_q.pop_front(), c);
    end else begin
      check({tag, "_missing"}, 0, 1);
    end
  endtask

  initial begin
    // reset state
    #12;
    check("rst_ready", ready_o, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_valid", valid_o, 0);
    check("rst_end", end_o, 0);
    check("rst_custo", custo_o, 0);
    @(negedge clk); rst_n = 1'b1;

    // full clear
    @(posedge clk); #1 limpar = 1'b1;
    @(posedge clk); #1 limpar = 1'b0;
    check("limpar_busy", ocupado, 1);
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (!ocupado) break;
    end
    check("limpar_done", ocupado, 0);
    check("limpar_m0", dut.mem[0][AW+DW], 0);
    check("limpar_m1023", dut.mem[1023][AW+DW], 0);

    // two accepted slots
    clr_payload(); set_slot(0, 5, 3, 2); set_slot(2, 9, 7, 1);
    fire(8'b0000_0101, 10'd1, lat);
    check("t1_lat", lat, 11);
    check("t1_npush", pa_q.size(), 2);
    chk_push("t1_p0", 5, 5);
    chk_push("t1_p1", 9, 8);
    check("t1_mem5", dut.mem[5], word(1'b1, 6'd3, 10'd1));
    check("t1_mem9", dut.mem[9], word(1'b1, 6'd7, 10'd1));

    // equal distance: rejected
    clr_payload(); set_slot(0, 5, 3, 2);
    fire(8'b0000_0001, 10'd2, lat);
    check("t2_lat", lat, 6);
    check("t2_npush", pa_q.size(), 0);
    check("t2_mem5", dut.mem[5], word(1'b1, 6'd3, 10'd1));

    // smaller distance: accepted
    clr_payload(); set_slot(0, 5, 2, 2);
    fire(8'b0000_0001, 10'd3, lat);
    check("t3_lat", lat, 7);
    check("t3_npush", pa_q.size(), 1);
    chk_push("t3_p0", 5, 4);
    check("t3_mem5", dut.mem[5], word(1'b1, 6'd2, 10'd3));

    // empty command
    clr_payload();
    fire(8'b0, 10'd0, lat);
    check("t4_lat", lat, 3);
    check("t4_npush", pa_q.size(), 0);

    // back-pressure for 10 cycles
    clr_payload(); set_slot(0, 20, 10, 3); set_slot(1, 21, 11, 0);
    ativo_ready = 1'b0;
    strobe(8'b0000_0011, 10'd4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_o) break;
    end
    check("t5_valid_up", valid_o, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_hold_valid", valid_o, 1);
      check("t5_hold_end", end_o, 20);
      check("t5_hold_custo", custo_o, 13);
    end
    check("t5_mem21_untouched", dut.mem[21][AW+DW], 0);
    @(posedge clk); #1 ativo_ready = 1'b1;
    wait_ready(lat);
    check("t5_npush", pa_q.size(), 2);
    chk_push("t5_p0", 20, 13);
    chk_push("t5_p1", 21, 11);

    // duplicates, improving order
    clr_payload(); set_slot(1, 12, 6, 1); set_slot(4, 12, 4, 1);
    fire(8'b0001_0010, 10'd5, lat);
    check("t6_npush", pa_q.size(), 2);
    chk_push("t6_p0", 12, 7);
    chk_push("t6_p1", 12, 5);
    check("t6_mem12", dut.mem[12], word(1'b1, 6'd4, 10'd5));

    // duplicates, reversed order
    clr_payload(); set_slot(1, 13, 4, 1); set_slot(4, 13, 6, 1);
    fire(8'b0001_0010, 10'd6, lat);
    check("t7_lat", lat, 1 + 4 + 3 + 2);
    check("t7_npush", pa_q.size(), 1);
    chk_push("t7_p0", 13, 5);
    check("t7_mem13", dut.mem[13], word(1'b1, 6'd4, 10'd6));

    // reset while pushing
    clr_payload(); set_slot(0, 30, 1, 1);
    ativo_ready = 1'b0;
    pulses_before = n_pulse;
    strobe(8'b0000_0001, 10'd7);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_o) break;
    end
    check("t8_valid_up", valid_o, 1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("t8_rst_valid", valid_o, 0);
    check("t8_rst_ocupado", ocupado, 0);
    check("t8_rst_end", end_o, 0);
    check("t8_rst_custo", custo_o, 0);
    check("t8_rst_ready", ready_o, 0);
    #1 rst_n = 1'b1; ativo_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t8_no_pulse", n_pulse, pulses_before);
    check("t8_npush_drop", pa_q.size(), 0);
    clr_payload(); set_slot(0, 31, 5, 2);
    fire(8'b0000_0001, 10'd7, lat);
    check("t8_lat", lat, 7);
    check("t8_npush", pa_q.size(), 1);
    chk_push("t8_p0", 31, 7);
    check("t8_mem31", dut.mem[31], word(1'b1, 6'd5, 10'd7));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
